// File: rtl/pipe_reg_hs_pkg.sv
// Shared constants and helpers for the handshaked pipeline register.
//   PIPE_PRESET_DEF : default reset value of stage data registers
//   occ_w()         : width needed to count 0..DEPTH valid stages
package pipe_reg_hs_pkg;

  localparam logic [31:0] PIPE_PRESET_DEF = 32'h0;

  function automatic int occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_hs_if.sv
// Valid/ready stream bundle.
//   valid : producer has a word
//   ready : consumer accepts the word this cycle
//   data  : payload
// master = producer side, slave = consumer side.
interface pipe_reg_hs_if #(
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg_hs_stage.sv
// One pipeline stage: valid bit + data register.
//   clk, arst_n : clock, async active-low reset
//   flush_i     : clear valid, data kept
//   en_i        : stage may advance (its ready)
//   vld_i/dat_i : word offered by the previous stage
//   vld_o/dat_o : stage contents
module pipe_stage
  import pipe_reg_hs_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] PRESET_VAL = DATA_W'(PIPE_PRESET_DEF)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush_i,
  input  logic              en_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o
);
  logic              v_q;
  logic [DATA_W-1:0] d_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v_q <= 1'b0;
      d_q <= PRESET_VAL;
    end else if (flush_i) begin
      v_q <= 1'b0;
    end else if (en_i) begin
      v_q <= vld_i;
      // data only loads when a real word moves in; bubbles leave stale data
      if (vld_i) d_q <= dat_i;
    end
  end

  assign vld_o = v_q;
  assign dat_o = d_q;
endmodule

// File: rtl/pipe_reg_hs.sv
// DEPTH-stage valid/ready pipeline register with bubble collapsing,
// backpressure, synchronous flush and an occupancy counter.
//   clk, arst_n : clock, async active-low reset
//   flush       : clears every valid bit next edge; blocks both handshakes now
//   up          : input stream (slave modport)
//   dn          : output stream (master modport), fed from stage DEPTH-1
//   occupancy   : number of valid stages (registered)
module pipe_reg_hs
  import pipe_reg_hs_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 2,
  parameter logic [DATA_W-1:0] PRESET_VAL = DATA_W'(PIPE_PRESET_DEF),
  localparam int               OCC_W      = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             flush,
  pipe_reg_hs_if.slave     up,
  pipe_reg_hs_if.master    dn,
  output logic [OCC_W-1:0] occupancy
);
  logic [DEPTH-1:0]             v;
  logic [DEPTH-1:0][DATA_W-1:0] d;
  logic [DEPTH-1:0]             rdy;
  logic [DEPTH-1:0]             vin;
  logic [DEPTH-1:0][DATA_W-1:0] din;
  logic                         in_rdy, in_xfer, out_vld, out_xfer;
  logic [OCC_W-1:0]             occ_q, occ_d;

  // Ready ripples back from the output in one cycle, so any empty stage
  // lets everything upstream of it move: bubbles collapse immediately.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = !v[DEPTH-1] | dn.ready;
    for (int i = DEPTH - 2; i >= 0; i--)
      rdy[i] = !v[i] | rdy[i+1];
  end

  assign in_rdy   = rdy[0] & !flush;
  assign in_xfer  = up.valid & in_rdy;
  assign out_vld  = v[DEPTH-1] & !flush;
  assign out_xfer = out_vld & dn.ready;

  always_comb begin
    vin    = '0;
    din    = '0;
    vin[0] = in_xfer;
    din[0] = up.data;
    for (int i = 1; i < DEPTH; i++) begin
      vin[i] = v[i-1];
      din[i] = d[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    pipe_stage #(
      .DATA_W     (DATA_W),
      .PRESET_VAL (PRESET_VAL)
    ) u_stg (
      .clk     (clk),
      .arst_n  (arst_n),
      .flush_i (flush),
      .en_i    (rdy[g]),
      .vld_i   (vin[g]),
      .dat_i   (din[g]),
      .vld_o   (v[g]),
      .dat_o   (d[g])
    );
  end

  // Counter tracks popcount(v) from the handshakes instead of summing bits.
  always_comb begin
    occ_d = occ_q;
    if (flush)                  occ_d = '0;
    else if (in_xfer & !out_xfer) occ_d = occ_q + OCC_W'(1);
    else if (!in_xfer & out_xfer) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) occ_q <= '0;
    else         occ_q <= occ_d;
  end

  assign up.ready  = in_rdy;
  assign dn.valid  = out_vld;
  assign dn.data   = d[DEPTH-1];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench: three pipes (DEPTH 3/4/1) checked every cycle against a
// position-list reference model; directed scenarios then random traffic.
module tb_pipe_reg_hs;
  localparam int DW = 16;
  localparam int N  = 3;
  localparam int DEP [N] = '{3, 4, 1};
  localparam logic [DW-1:0] PRE0 = 16'h1234;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk = ~clk;

  logic          fl   [N];
  logic          iv   [N];
  logic [DW-1:0] id   [N];
  logic          ordy [N];

  pipe_reg_hs_if #(.DATA_W(DW)) ui0 (), di0 (), ui1 (), di1 (), ui2 (), di2 ();
  logic [1:0] occ0;
  logic [2:0] occ1;
  logic [0:0] occ2;

  assign ui0.valid = iv[0]; assign ui0.data = id[0]; assign di0.ready = ordy[0];
  assign ui1.valid = iv[1]; assign ui1.data = id[1]; assign di1.ready = ordy[1];
  assign ui2.valid = iv[2]; assign ui2.data = id[2]; assign di2.ready = ordy[2];

  pipe_reg_hs #(.DATA_W(DW), .DEPTH(3), .PRESET_VAL(PRE0)) dut0 (
    .clk(clk), .arst_n(arst_n), .flush(fl[0]), .up(ui0), .dn(di0), .occupancy(occ0));
  pipe_reg_hs #(.DATA_W(DW), .DEPTH(4), .PRESET_VAL(16'h0)) dut1 (
    .clk(clk), .arst_n(arst_n), .flush(fl[1]), .up(ui1), .dn(di1), .occupancy(occ1));
  pipe_reg_hs #(.DATA_W(DW), .DEPTH(1), .PRESET_VAL(16'h0)) dut2 (
    .clk(clk), .arst_n(arst_n), .flush(fl[2]), .up(ui2), .dn(di2), .occupancy(occ2));

  logic          o_irdy [N];
  logic          o_ov   [N];
  logic [DW-1:0] o_od   [N];
  logic [3:0]    o_occ  [N];
  assign o_irdy[0] = ui0.ready; assign o_ov[0] = di0.valid; assign o_od[0] = di0.data; assign o_occ[0] = 4'(occ0);
  assign o_irdy[1] = ui1.ready; assign o_ov[1] = di1.valid; assign o_od[1] = di1.data; assign o_occ[1] = 4'(occ1);
  assign o_irdy[2] = ui2.ready; assign o_ov[2] = di2.valid; assign o_od[2] = di2.data; assign o_occ[2] = 4'(occ2);

  // Reference: ordered list of words with their stage position
  logic [DW-1:0] md   [N][8];
  int            mp   [N][8];
  int            mcnt [N];
  bit            pst  [N];
  logic [DW-1:0] pd   [N];
  bit            acc  [N];
  logic [DW-1:0] olog [N][16];
  int            ocnt [N];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < N; k++) begin
      mcnt[k] = 0; pst[k] = 0; acc[k] = 0;
    end
  endtask

  // Check all pipes against the model, advance the model, run one clock.
  task automatic cyc();
    #1;
    for (int k = 0; k < N; k++) begin
      int D, lim, np;
      bit er, ev, ox;
      string nm;
      nm = $sformatf("d%0d", k);
      D  = DEP[k];
      er = !fl[k] && (mcnt[k] < D || ordy[k]);
      ev = !fl[k] && mcnt[k] > 0 && mp[k][0] == D - 1;
      chk({nm, " in_ready"},  32'(o_irdy[k]), 32'(er));
      chk({nm, " out_valid"}, 32'(o_ov[k]),   32'(ev));
      chk({nm, " occupancy"}, 32'(o_occ[k]),  32'(mcnt[k]));
      if (ev) chk({nm, " out_data"}, 32'(o_od[k]), 32'(md[k][0]));
      if (pst[k] && iv[k]) chk({nm, " in_data held"}, 32'(id[k]), 32'(pd[k]));
      if (o_ov[k] && ordy[k] && ocnt[k] < 16) begin
        olog[k][ocnt[k]] = o_od[k];
        ocnt[k]++;
      end
      pst[k] = iv[k] && !er;
      pd[k]  = id[k];
      acc[k] = iv[k] && er;
      ox     = ev && ordy[k];
      if (fl[k]) mcnt[k] = 0;
      else begin
        if (ox) begin
          for (int j = 1; j < mcnt[k]; j++) begin
            md[k][j-1] = md[k][j]; mp[k][j-1] = mp[k][j];
          end
          mcnt[k]--;
        end
        // each word moves one stage unless the word ahead stays put
        lim = D;
        for (int j = 0; j < mcnt[k]; j++) begin
          np = (mp[k][j] + 1 < lim - 1) ? mp[k][j] + 1 : lim - 1;
          mp[k][j] = np;
          lim = np;
        end
        if (acc[k]) begin
          md[k][mcnt[k]] = id[k]; mp[k][mcnt[k]] = 0; mcnt[k]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int k, input logic [DW-1:0] w);
    iv[k] = 1'b1; id[k] = w; acc[k] = 0;
    for (int c = 0; c < 20 && !acc[k]; c++) cyc();
    chk($sformatf("d%0d push accepted", k), 32'(acc[k]), 32'(1'b1));
    iv[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      fl[k] = 0; iv[k] = 0; id[k] = '0; ordy[k] = 0; ocnt[k] = 0;
    end
    mreset();
    #2 arst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("d%0d reset out_valid", k), 32'(o_ov[k]), 32'(1'b0));
      chk($sformatf("d%0d reset occupancy", k), 32'(o_occ[k]), 32'(0));
      chk($sformatf("d%0d reset in_ready", k), 32'(o_irdy[k]), 32'(1'b1));
      chk($sformatf("d%0d reset out_data", k), 32'(o_od[k]), (k == 0) ? 32'(PRE0) : 32'(0));
    end
    @(negedge clk);
    arst_n = 1'b1;

    // 1: streaming through DEPTH=3
    ordy[0] = 1; ocnt[0] = 0;
    for (int i = 1; i <= 4; i++) begin iv[0] = 1; id[0] = 16'(i); cyc(); end
    iv[0] = 0;
    repeat (5) cyc();
    chk("t1 out count", 32'(ocnt[0]), 32'(4));
    for (int i = 0; i < 4; i++) chk($sformatf("t1 out[%0d]", i), 32'(olog[0][i]), 32'(i + 1));

    // 2: backpressure, full pipe, release
    ordy[0] = 0; ocnt[0] = 0;
    push(0, 16'hA); push(0, 16'hB); push(0, 16'hC);
    iv[0] = 1; id[0] = 16'hD;
    repeat (3) cyc();
    #1;
    chk("t2 full occupancy", 32'(o_occ[0]), 32'(3));
    chk("t2 full in_ready", 32'(o_irdy[0]), 32'(1'b0));
    ordy[0] = 1;
    push(0, 16'hD);
    repeat (6) cyc();
    chk("t2 out count", 32'(ocnt[0]), 32'(4));
    for (int i = 0; i < 4; i++) chk($sformatf("t2 out[%0d]", i), 32'(olog[0][i]), 32'(10 + i));

    // 3: single word collapses through idle DEPTH=4 pipe
    ordy[1] = 0;
    iv[1] = 1; id[1] = 16'h55; cyc();
    iv[1] = 0;
    repeat (3) cyc();
    #1;
    chk("t3 out_valid", 32'(o_ov[1]), 32'(1'b1));
    chk("t3 out_data", 32'(o_od[1]), 32'h55);
    chk("t3 occupancy", 32'(o_occ[1]), 32'(1));
    chk("t3 in_ready", 32'(o_irdy[1]), 32'(1'b1));
    ordy[1] = 1;
    repeat (3) cyc();

    // 4: flush with two words inside and a word offered
    ordy[1] = 0;
    push(1, 16'h11); push(1, 16'h22);
    ocnt[1] = 0;
    fl[1] = 1; iv[1] = 1; id[1] = 16'h99;
    #1;
    chk("t4 flush in_ready", 32'(o_irdy[1]), 32'(1'b0));
    chk("t4 flush out_valid", 32'(o_ov[1]), 32'(1'b0));
    cyc();
    fl[1] = 0; iv[1] = 0;
    #1;
    chk("t4 post occupancy", 32'(o_occ[1]), 32'(0));
    chk("t4 post out_valid", 32'(o_ov[1]), 32'(1'b0));
    ordy[1] = 1;
    repeat (6) cyc();
    chk("t4 nothing emerged", 32'(ocnt[1]), 32'(0));

    // 5: async reset between edges with full DEPTH=3 pipe
    ordy[0] = 0;
    push(0, 16'h21); push(0, 16'h22); push(0, 16'h23);
    #2 arst_n = 1'b0;
    #1;
    chk("t5 out_valid", 32'(o_ov[0]), 32'(1'b0));
    chk("t5 occupancy", 32'(o_occ[0]), 32'(0));
    chk("t5 out_data", 32'(o_od[0]), 32'(PRE0));
    chk("t5 in_ready", 32'(o_irdy[0]), 32'(1'b1));
    mreset();
    @(negedge clk);
    arst_n = 1'b1;

    // 6: random traffic on all three pipes
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pst[k]) begin
          iv[k] = 1'($urandom_range(0, 1));
          id[k] = 16'($urandom);
        end
        ordy[k] = 1'($urandom_range(0, 1));
        fl[k]   = ($urandom_range(0, 49) == 0);
      end
      cyc();
    end
    for (int k = 0; k < N; k++) begin iv[k] = 0; fl[k] = 0; ordy[k] = 1; end
    repeat (6) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
